// File: rtl/sha256_chain_sched.sv
// sha256_chain_sched
//   Scheduler between a host word stream and NUM_CORES calc_sha cores on one
//   clock. Host words are routed to the core named by s_chan. Each captured
//   digest is fed back into the same core s_repeat more times. Finished hashes
//   leave through a round-robin arbitrated, back-pressured result register.
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   s_valid/s_ready     : host word handshake; s_data, s_keep, s_last, s_chan,
//                         s_repeat (sampled on the first word of a message)
//   core_*_o            : per-core word lanes (core k owns slice k)
//   core_digest_i       : per-core digest, with core_digest_valid_i strobes
//   res_valid/res_ready : result handshake; res_hash, res_chan
//   err_o               : sticky per-channel error flags
//   done_cnt_o          : count of delivered results (wraps)
module sha256_chain_sched #(
  parameter int  NUM_CORES = 8,
  parameter int  REP_W     = 20,
  localparam int CHAN_W    = $clog2(NUM_CORES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [31:0]              s_data,
  input  logic [3:0]               s_keep,
  input  logic                     s_last,
  input  logic [CHAN_W-1:0]        s_chan,
  input  logic [REP_W-1:0]         s_repeat,
  output logic [NUM_CORES-1:0]     core_valid_o,
  output logic [NUM_CORES*32-1:0]  core_data_o,
  output logic [NUM_CORES*4-1:0]   core_keep_o,
  output logic [NUM_CORES-1:0]     core_last_o,
  input  logic [NUM_CORES*256-1:0] core_digest_i,
  input  logic [NUM_CORES-1:0]     core_digest_valid_i,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [255:0]             res_hash,
  output logic [CHAN_W-1:0]        res_chan,
  output logic [NUM_CORES-1:0]     err_o,
  output logic [31:0]              done_cnt_o
);
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_FEED, ST_DONE} state_t;

  state_t                  state_q [NUM_CORES];
  state_t                  state_d [NUM_CORES];
  logic [REP_W-1:0]        rep_q   [NUM_CORES];
  logic [REP_W-1:0]        rep_d   [NUM_CORES];
  logic [2:0]              cnt_q   [NUM_CORES];
  logic [2:0]              cnt_d   [NUM_CORES];
  logic [255:0]            hash_q  [NUM_CORES];
  logic [255:0]            hash_d  [NUM_CORES];
  logic [NUM_CORES-1:0]    core_valid_q, core_valid_d;
  logic [NUM_CORES*32-1:0] core_data_q, core_data_d;
  logic [NUM_CORES*4-1:0]  core_keep_q, core_keep_d;
  logic [NUM_CORES-1:0]    core_last_q, core_last_d;
  logic                    res_valid_q, res_valid_d;
  logic [255:0]            res_hash_q, res_hash_d;
  logic [CHAN_W-1:0]       res_chan_q, res_chan_d;
  logic [CHAN_W-1:0]       rr_q, rr_d;
  logic [NUM_CORES-1:0]    err_q, err_d;
  logic [31:0]             done_cnt_q, done_cnt_d;

  logic                    sel_busy;
  logic                    accept;
  logic [NUM_CORES-1:0]    elig;
  logic                    grant_found;
  int                      probe;

  // Ready depends only on the addressed channel's current state. An
  // out-of-range channel matches no entry, so its word is accepted and,
  // matching no channel below, simply dropped.
  always_comb begin
    sel_busy = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (s_chan == CHAN_W'(c)) begin
        sel_busy = !(state_q[c] == ST_IDLE || state_q[c] == ST_LOAD);
      end
    end
    s_ready = !sel_busy;
    accept  = s_valid && s_ready;
  end

  always_comb begin
    state_d      = state_q;
    rep_d        = rep_q;
    cnt_d        = cnt_q;
    hash_d       = hash_q;
    core_valid_d = '0;
    core_data_d  = '0;
    core_keep_d  = '0;
    core_last_d  = '0;
    err_d        = err_q;
    res_valid_d  = res_valid_q;
    res_hash_d   = res_hash_q;
    res_chan_d   = res_chan_q;
    rr_d         = rr_q;
    done_cnt_d   = done_cnt_q;
    elig         = '0;
    grant_found  = 1'b0;
    probe        = 0;

    for (int c = 0; c < NUM_CORES; c++) begin
      case (state_q[c])
        ST_IDLE, ST_LOAD: begin
          if (accept && s_chan == CHAN_W'(c)) begin
            if (state_q[c] == ST_IDLE) rep_d[c] = s_repeat;
            state_d[c]              = s_last ? ST_WAIT : ST_LOAD;
            core_valid_d[c]         = 1'b1;
            core_data_d[c*32 +: 32] = s_data;
            core_keep_d[c*4 +: 4]   = s_keep;
            core_last_d[c]          = s_last;
          end
        end
        ST_WAIT: begin
          if (core_digest_valid_i[c]) begin
            hash_d[c] = core_digest_i[c*256 +: 256];
            if (rep_q[c] == '0) begin
              state_d[c] = ST_DONE;
            end else begin
              // Word 0 goes out straight from the incoming digest so the
              // burst starts the cycle after the strobe; FEED then counts
              // words 1..7 out of the captured hash.
              state_d[c]              = ST_FEED;
              rep_d[c]                = rep_q[c] - REP_W'(1);
              cnt_d[c]                = 3'd1;
              core_valid_d[c]         = 1'b1;
              core_data_d[c*32 +: 32] = core_digest_i[c*256+224 +: 32];
              core_keep_d[c*4 +: 4]   = 4'hF;
            end
          end
        end
        ST_FEED: begin
          core_valid_d[c]         = 1'b1;
          core_data_d[c*32 +: 32] = hash_q[c][{3'd7 - cnt_q[c], 5'd0} +: 32];
          core_keep_d[c*4 +: 4]   = 4'hF;
          core_last_d[c]          = (cnt_q[c] == 3'd7);
          if (cnt_q[c] == 3'd7) state_d[c] = ST_WAIT;
          else                  cnt_d[c]   = cnt_q[c] + 3'd1;
        end
        default: ;
      endcase
      if (core_digest_valid_i[c] && state_q[c] != ST_WAIT) err_d[c] = 1'b1;
    end

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
      done_cnt_d  = done_cnt_q + 32'd1;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (res_chan_q == CHAN_W'(c)) state_d[c] = ST_IDLE;
      end
    end

    // The channel sitting in the result register stays DONE until its
    // handshake, so it is masked out of arbitration while res_valid is high.
    for (int c = 0; c < NUM_CORES; c++) begin
      elig[c] = (state_q[c] == ST_DONE) && !(res_valid_q && res_chan_q == CHAN_W'(c));
    end

    if (!res_valid_q || res_ready) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        probe = int'(rr_q) + i;
        if (probe >= NUM_CORES) probe = probe - NUM_CORES;
        for (int c = 0; c < NUM_CORES; c++) begin
          if (!grant_found && c == probe && elig[c]) begin
            grant_found = 1'b1;
            res_valid_d = 1'b1;
            res_hash_d  = hash_q[c];
            res_chan_d  = CHAN_W'(c);
            rr_d        = (c == NUM_CORES - 1) ? '0 : CHAN_W'(c + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        state_q[c] <= ST_IDLE;
        rep_q[c]   <= '0;
        cnt_q[c]   <= '0;
      end
      core_valid_q <= '0;
      core_data_q  <= '0;
      core_keep_q  <= '0;
      core_last_q  <= '0;
      res_valid_q  <= 1'b0;
      res_hash_q   <= '0;
      res_chan_q   <= '0;
      rr_q         <= '0;
      err_q        <= '0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rep_q        <= rep_d;
      cnt_q        <= cnt_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      core_keep_q  <= core_keep_d;
      core_last_q  <= core_last_d;
      res_valid_q  <= res_valid_d;
      res_hash_q   <= res_hash_d;
      res_chan_q   <= res_chan_d;
      rr_q         <= rr_d;
      err_q        <= err_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  // Hash storage is only read after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    hash_q <= hash_d;
  end

  assign core_valid_o = core_valid_q;
  assign core_data_o  = core_data_q;
  assign core_keep_o  = core_keep_q;
  assign core_last_o  = core_last_q;
  assign res_valid    = res_valid_q;
  assign res_hash     = res_hash_q;
  assign res_chan     = res_chan_q;
  assign err_o        = err_q;
  assign done_cnt_o   = done_cnt_q;
endmodule

// File: tb/tb_sha256_chain_sched.sv
// Directed bench for sha256_chain_sched: an 8-core instance for the main
// flows and a 6-core instance for out-of-range channel handling.
module tb_sha256_chain_sched;
  logic          clk;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [31:0]   s_data;
  logic [3:0]    s_keep;
  logic [2:0]    s_chan;
  logic [19:0]   s_repeat;
  logic [7:0]    core_valid_o, core_last_o, core_digest_valid_i, err_o;
  logic [255:0]  core_data_o;
  logic [31:0]   core_keep_o;
  logic [2047:0] core_digest_i;
  logic          res_valid, res_ready;
  logic [255:0]  res_hash;
  logic [2:0]    res_chan;
  logic [31:0]   done_cnt_o;

  logic          s6_valid, s6_ready;
  logic [31:0]   s6_data;
  logic [2:0]    s6_chan;
  logic [5:0]    cv6, cl6, err6;
  logic [191:0]  cd6;
  logic [23:0]   ck6;
  logic          r6_valid;
  logic [255:0]  r6_hash;
  logic [2:0]    r6_chan;
  logic [31:0]   d6cnt;

  int errors = 0;
  int checks = 0;
  int vcnt [8];
  int lcnt [8];
  logic cnt_clr;
  int stable;

  sha256_chain_sched #(.NUM_CORES(8), .REP_W(20)) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_chan(s_chan), .s_repeat(s_repeat),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o),
    .core_keep_o(core_keep_o), .core_last_o(core_last_o),
    .core_digest_i(core_digest_i), .core_digest_valid_i(core_digest_valid_i),
    .res_valid(res_valid), .res_ready(res_ready), .res_hash(res_hash),
    .res_chan(res_chan), .err_o(err_o), .done_cnt_o(done_cnt_o)
  );

  sha256_chain_sched #(.NUM_CORES(6), .REP_W(20)) u_dut6 (
    .clk(clk), .rst(rst),
    .s_valid(s6_valid), .s_ready(s6_ready), .s_data(s6_data), .s_keep(4'hF),
    .s_last(1'b1), .s_chan(s6_chan), .s_repeat(20'd0),
    .core_valid_o(cv6), .core_data_o(cd6), .core_keep_o(ck6), .core_last_o(cl6),
    .core_digest_i(1536'd0), .core_digest_valid_i(6'd0),
    .res_valid(r6_valid), .res_ready(1'b1), .res_hash(r6_hash),
    .res_chan(r6_chan), .err_o(err6), .done_cnt_o(d6cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (cnt_clr) begin
        vcnt[k] <= 0;
        lcnt[k] <= 0;
      end else begin
        vcnt[k] <= vcnt[k] + int'(core_valid_o[k]);
        lcnt[k] <= lcnt[k] + int'(core_valid_o[k] & core_last_o[k]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word and hold it until the handshake edge (bounded).
  task automatic send(input logic [2:0] ch, input logic [31:0] d, input logic last,
                      input logic [19:0] rep);
    logic acc;
    acc      = 1'b0;
    s_valid  = 1'b1;
    s_chan   = ch;
    s_data   = d;
    s_keep   = 4'hF;
    s_last   = last;
    s_repeat = rep;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", acc, 1);
  endtask

  task automatic set_dig(input int ch, input logic [255:0] d);
    core_digest_i[ch*256 +: 256] = d;
  endtask

  task automatic pulse(input logic [7:0] mask);
    core_digest_valid_i = mask;
    @(posedge clk);
    #1;
    core_digest_valid_i = '0;
  endtask

  // Digest whose word k (most significant first) is base+k.
  function automatic logic [255:0] mkd(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[255-32*k -: 32] = base + 32'(k);
    return r;
  endfunction

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_chan = '0; s_data = '0; s_keep = '0;
    s_last = 1'b0; s_repeat = '0; core_digest_i = '0; core_digest_valid_i = '0;
    res_ready = 1'b0; cnt_clr = 1'b1; s6_valid = 1'b0; s6_chan = '0; s6_data = '0;
    tick(3);
    chk("rst_core_valid", core_valid_o, 0);
    chk("rst_core_data", core_data_o, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_hash", res_hash, 0);
    chk("rst_res_chan", res_chan, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done_cnt", done_cnt_o, 0);
    rst = 1'b0;
    tick(1);
    chk("ready_after_rst", s_ready, 1);
    chk("d6_idle_res", {r6_valid, r6_chan, d6cnt}, 0);
    chk("d6_idle_hash", r6_hash, 0);

    // Single pass on channel 0
    res_ready = 1'b1;
    cnt_clr   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(3'd0, 32'h1000_0000 + 32'(i), i == 15, 20'd0);
      if (i == 0) begin
        chk("t1_first_valid", core_valid_o, 8'h01);
        chk("t1_first_data", core_data_o[31:0], 32'h1000_0000);
      end
    end
    s_valid = 1'b0;
    tick(9);
    set_dig(0, mkd(32'hD000_0000));
    pulse(8'h01);
    chk("t1_no_feed", core_valid_o, 0);
    tick(1);
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_hash", res_hash, mkd(32'hD000_0000));
    chk("t1_res_chan", res_chan, 0);
    tick(1);
    chk("t1_done_cnt", done_cnt_o, 1);
    chk("t1_res_cleared", res_valid, 0);
    chk("t1_core0_words", vcnt[0], 16);
    chk("t1_core0_lasts", lcnt[0], 1);

    // Three channels finishing together, round-robin from channel 1
    send(3'd1, 32'hA1, 1'b1, 20'd0);
    send(3'd2, 32'hA2, 1'b1, 20'd0);
    send(3'd5, 32'hA5, 1'b1, 20'd0);
    s_valid = 1'b0;
    tick(1);
    set_dig(1, mkd(32'h1100_0000));
    set_dig(2, mkd(32'h2200_0000));
    set_dig(5, mkd(32'h5500_0000));
    pulse(8'b0010_0110);
    chk("rr_not_yet", res_valid, 0);
    tick(1);
    chk("rr_1_valid", res_valid, 1);
    chk("rr_1_chan", res_chan, 1);
    chk("rr_1_hash", res_hash, mkd(32'h1100_0000));
    tick(1);
    chk("rr_2_chan", res_chan, 2);
    chk("rr_2_hash", res_hash, mkd(32'h2200_0000));
    tick(1);
    chk("rr_3_chan", res_chan, 5);
    chk("rr_3_hash", res_hash, mkd(32'h5500_0000));
    tick(1);
    chk("rr_drained", res_valid, 0);

    // Pointer advance: after granting 1 the search starts at 2, so 3 beats 0
    send(3'd1, 32'hB1, 1'b1, 20'd0);
    s_valid = 1'b0;
    set_dig(1, mkd(32'h1200_0000));
    pulse(8'h02);
    tick(1);
    chk("ptr_solo_chan", res_chan, 1);
    tick(1);
    send(3'd0, 32'hB0, 1'b1, 20'd0);
    send(3'd3, 32'hB3, 1'b1, 20'd0);
    s_valid = 1'b0;
    set_dig(0, mkd(32'h0300_0000));
    set_dig(3, mkd(32'h3300_0000));
    pulse(8'h09);
    tick(1);
    chk("ptr_first_chan", res_chan, 3);
    chk("ptr_first_hash", res_hash, mkd(32'h3300_0000));
    tick(1);
    chk("ptr_second_chan", res_chan, 0);
    chk("ptr_second_hash", res_hash, mkd(32'h0300_0000));
    tick(1);
    chk("ptr_done_cnt", done_cnt_o, 7);

    // Chaining on channel 3, two extra passes; repeat from word 2 is ignored
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    send(3'd3, 32'hC0DE_0001, 1'b0, 20'd2);
    send(3'd3, 32'hC0DE_0002, 1'b1, 20'd5);
    chk("t2_host_last", core_last_o, 8'h08);
    s_valid = 1'b0;
    tick(2);
    set_dig(3, mkd(32'hA000_0000));
    pulse(8'h08);
    chk("t2_feed_keep", core_keep_o, 32'h0000_F000);
    for (int k = 0; k < 8; k++) begin
      chk("t2_feed_data", core_data_o[127:96], 32'hA000_0000 + 32'(k));
      chk("t2_feed_vl", {core_valid_o, core_last_o}, {8'h08, (k == 7) ? 8'h08 : 8'h00});
      tick(1);
    end
    chk("t2_feed_end", core_valid_o, 0);
    tick(3);
    set_dig(3, mkd(32'hB000_0000));
    pulse(8'h08);
    tick(10);
    set_dig(3, mkd(32'hC000_0000));
    pulse(8'h08);
    chk("t2_no_feed3", core_valid_o, 0);
    tick(1);
    chk("t2_res_valid", res_valid, 1);
    chk("t2_res_hash", res_hash, mkd(32'hC000_0000));
    chk("t2_res_chan", res_chan, 3);
    tick(1);
    chk("t2_core3_words", vcnt[3], 18);
    chk("t2_core3_lasts", lcnt[3], 3);
    chk("t2_done_cnt", done_cnt_o, 8);

    // Backpressure on the result port
    res_ready = 1'b0;
    send(3'd6, 32'hE6, 1'b1, 20'd0);
    s_valid = 1'b0;
    set_dig(6, mkd(32'h6600_0000));
    pulse(8'h40);
    tick(1);
    chk("bp_valid", res_valid, 1);
    chk("bp_chan", res_chan, 6);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (res_valid === 1'b1 && res_hash === mkd(32'h6600_0000) && res_chan === 3'd6) stable++;
    end
    chk("bp_stable", stable, 20);
    s_valid = 1'b1; s_chan = 3'd6; s_last = 1'b1; s_data = 32'hE7;
    #1;
    chk("bp_done_ready", s_ready, 0);
    s_chan = 3'd7;
    #1;
    chk("bp_idle_ready", s_ready, 1);
    send(3'd7, 32'h7777_0007, 1'b1, 20'd0);
    s_valid = 1'b0;
    chk("bp_idle_fwd", core_valid_o, 8'h80);
    chk("bp_cnt_hold", done_cnt_o, 8);
    res_ready = 1'b1;
    tick(1);
    chk("bp_done_cnt", done_cnt_o, 9);
    chk("bp_res_clear", res_valid, 0);
    s_chan = 3'd6;
    #1;
    chk("bp_chan6_free", s_ready, 1);

    // Error flags
    tick(1);
    set_dig(4, mkd(32'h4400_0000));
    pulse(8'h10);
    chk("err_stray", err_o, 8'h10);
    tick(3);
    chk("err_no_result", res_valid, 0);
    s6_valid = 1'b1; s6_chan = 3'd7; s6_data = 32'hBAD0_0007;
    #1;
    chk("oor_ready", s6_ready, 1);
    tick(1);
    s6_valid = 1'b0;
    chk("oor_dropped", {cv6, cl6}, 0);
    chk("oor_no_err", err6, 0);
    s6_valid = 1'b1; s6_chan = 3'd5; s6_data = 32'h6005_0005;
    #1;
    chk("d6_ready", s6_ready, 1);
    tick(1);
    s6_valid = 1'b0;
    chk("d6_fwd_valid", cv6, 6'h20);
    chk("d6_fwd_data", cd6, {32'h6005_0005, 160'd0});
    chk("d6_fwd_keep", ck6, 24'hF0_0000);

    // Reset in the middle of a FEED burst with a result pending
    res_ready = 1'b0;
    send(3'd5, 32'hF5, 1'b1, 20'd0);
    send(3'd2, 32'hF2, 1'b1, 20'd1);
    s_valid = 1'b0;
    set_dig(5, mkd(32'h5A00_0000));
    set_dig(2, mkd(32'h2A00_0000));
    pulse(8'h24);
    tick(2);
    chk("mr_pending", res_valid, 1);
    chk("mr_feeding", core_valid_o, 8'h04);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_core_valid", core_valid_o, 0);
    chk("mr_core_data", core_data_o, 0);
    chk("mr_res_valid", res_valid, 0);
    chk("mr_err", err_o, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    res_ready = 1'b1;
    send(3'd2, 32'hF3, 1'b1, 20'd0);
    s_valid = 1'b0;
    set_dig(2, mkd(32'h2B00_0000));
    pulse(8'h04);
    chk("mr_no_feed", core_valid_o, 0);
    tick(1);
    chk("mr_res_valid2", res_valid, 1);
    chk("mr_res_chan", res_chan, 2);
    chk("mr_res_hash", res_hash, mkd(32'h2B00_0000));
    tick(1);
    chk("mr_done_cnt", done_cnt_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
